// File: rtl/game_pkg.sv
// game_pkg: shared encodings, constants and line-addressing helper for the 2048 controller
package game_pkg;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_SLIDE, ST_COMMIT, ST_SPAWN} state_t;
    localparam int CELL_BITS  = 4;
    localparam int MAX_TILE   = 15;
    localparam int FADE_START = 7;
    // Cell index {y,x} of element k of line r when sliding in direction d; 3-k is ~k on two bits
    function automatic logic [3:0] cell_idx(input dir_t d, input logic [1:0] r, input logic [1:0] k);
        return d == DIR_LEFT  ? {r, k} :
               d == DIR_RIGHT ? {r, ~k} :
               d == DIR_UP    ? {k, r} : {~k, r};
    endfunction
endpackage

// File: rtl/row_merge.sv
// row_merge: compacts a 4-cell line toward element 0 and merges equal neighbours once, saturating
module row_merge
    import game_pkg::*;
(
    input  logic [15:0] line_in,
    output logic [15:0] line_out
);
    logic [3:0][CELL_BITS-1:0] m;

    function automatic logic [3:0][CELL_BITS-1:0] compact(input logic [3:0][CELL_BITS-1:0] v);
        logic [3:0][CELL_BITS-1:0] c;
        logic [2:0] n;
        c = '0;
        n = '0;
        for (int i = 0; i < 4; i++)
            if (v[i] != '0) begin
                c[n[1:0]] = v[i];
                n = n + 3'd1;
            end
        return c;
    endfunction

    // A merged slot is followed by a zero, so the scan never merges the same tile twice
    always_comb begin
        m = compact(line_in);
        for (int i = 0; i < 3; i++)
            if (m[i] != '0 && m[i] == m[i+1]) begin
                m[i]   = m[i] == CELL_BITS'(MAX_TILE) ? m[i] : m[i] + 4'd1;
                m[i+1] = '0;
            end
        line_out = compact(m);
    end
endmodule

// File: rtl/game_controller.sv
// game_controller: 2048 move/merge/spawn sequencer with LFSR tile placement and new-tile fade
module game_controller
    import game_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          FADE_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    input  logic        new_game,
    input  logic        load_en,
    input  logic [63:0] load_grid,
    input  logic        frame_tick,
    output logic [63:0] grid,
    output logic [15:0] new_tiles,
    output logic [2:0]  new_tiles_counter,
    output logic        game_over
);
    localparam int DW = $clog2(FADE_DIV + 1);

    state_t      state;
    dir_t        dir_q;
    logic [1:0]  row;
    logic [63:0] shadow;
    logic [15:0] lfsr;
    logic [3:0]  scan_idx, scan_cnt;
    logic        second_spawn;
    logic [DW-1:0] div;
    logic [15:0] line_in, line_out;
    logic        spawn_hit, board_full, has_pair;

    row_merge u_row_merge (.line_in(line_in), .line_out(line_out));

    always_comb begin
        line_in = '0;
        for (int k = 0; k < 4; k++)
            line_in[4*k +: 4] = grid[{cell_idx(dir_q, row, 2'(k)), 2'b00} +: 4];
    end

    always_comb begin
        board_full = 1'b1;
        has_pair   = 1'b0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) begin
                if (grid[{2'(y), 2'(x), 2'b00} +: 4] == 4'd0) board_full = 1'b0;
                if (x < 3 && grid[{2'(y), 2'(x), 2'b00} +: 4] == grid[{2'(y), 2'(x + 1), 2'b00} +: 4]) has_pair = 1'b1;
                if (y < 3 && grid[{2'(y), 2'(x), 2'b00} +: 4] == grid[{2'(y + 1), 2'(x), 2'b00} +: 4]) has_pair = 1'b1;
            end
    end

    assign spawn_hit = state == ST_SPAWN && grid[{scan_idx, 2'b00} +: 4] == 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_INIT;
            dir_q             <= DIR_UP;
            row               <= '0;
            shadow            <= '0;
            lfsr              <= LFSR_SEED;
            scan_idx          <= '0;
            scan_cnt          <= '0;
            second_spawn      <= 1'b0;
            div               <= '0;
            grid              <= '0;
            new_tiles         <= '0;
            new_tiles_counter <= '0;
            game_over         <= 1'b0;
            move_ready        <= 1'b0;
        end else begin
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            game_over <= board_full & ~has_pair;
            if (spawn_hit) begin
                new_tiles_counter <= 3'(FADE_START);
                div               <= '0;
            end else if (new_tiles_counter != 3'd0 && frame_tick) begin
                if (div == DW'(FADE_DIV - 1)) begin
                    div               <= '0;
                    new_tiles_counter <= new_tiles_counter - 3'd1;
                end else
                    div <= div + 1'b1;
            end
            case (state)
                ST_INIT: begin
                    second_spawn <= 1'b1;
                    scan_idx     <= lfsr[3:0];
                    scan_cnt     <= '0;
                    state        <= ST_SPAWN;
                end
                ST_IDLE: begin
                    if (new_game) begin
                        grid       <= '0;
                        new_tiles  <= '0;
                        move_ready <= 1'b0;
                        state      <= ST_INIT;
                    end else if (load_en) begin
                        grid              <= load_grid;
                        new_tiles         <= '0;
                        new_tiles_counter <= '0;
                        div               <= '0;
                    end else if (move_valid) begin
                        dir_q      <= dir_t'(move_dir);
                        row        <= '0;
                        move_ready <= 1'b0;
                        state      <= ST_SLIDE;
                    end
                end
                ST_SLIDE: begin
                    for (int k = 0; k < 4; k++)
                        shadow[{cell_idx(dir_q, row, 2'(k)), 2'b00} +: 4] <= line_out[4*k +: 4];
                    row <= row + 2'd1;
                    if (row == 2'd3) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    grid <= shadow;
                    if (shadow != grid) begin
                        scan_idx <= lfsr[3:0];
                        scan_cnt <= '0;
                        state    <= ST_SPAWN;
                    end else begin
                        move_ready <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                ST_SPAWN: begin
                    if (spawn_hit) begin
                        grid[{scan_idx, 2'b00} +: 4] <= lfsr[7:4] == 4'd0 ? 4'd2 : 4'd1;
                        new_tiles                    <= 16'd1 << scan_idx;
                    end
                    if (spawn_hit || scan_cnt == 4'd15) begin
                        if (second_spawn) begin
                            second_spawn <= 1'b0;
                            scan_idx     <= lfsr[3:0];
                            scan_cnt     <= '0;
                        end else begin
                            move_ready <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: scoreboard bench for the 2048 game controller
module tb_game_controller;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        move_valid = 1'b0, new_game = 1'b0, load_en = 1'b0, frame_tick = 1'b0;
    logic [1:0]  move_dir = 2'd0;
    logic [63:0] load_grid = '0;
    logic        move_ready, game_over;
    logic [63:0] grid;
    logic [15:0] new_tiles;
    logic [2:0]  new_tiles_counter;
    int checks = 0, failures = 0;

    typedef struct {string tag; logic [63:0] exp;} exp_t;
    exp_t sb[$];

    game_controller #(.LFSR_SEED(16'hACE1), .FADE_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .move_dir(move_dir),
        .move_ready(move_ready), .new_game(new_game), .load_en(load_en), .load_grid(load_grid),
        .frame_tick(frame_tick), .grid(grid), .new_tiles(new_tiles),
        .new_tiles_counter(new_tiles_counter), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] e);
        sb.push_back('{tag, e});
    endtask

    task automatic sb_pop(input logic [63:0] got);
        exp_t e;
        if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else begin
            e = sb.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_pos(input int d, input int r, input int k);
        case (d)
            0:       return k * 4 + r;
            1:       return (3 - k) * 4 + r;
            2:       return r * 4 + k;
            default: return r * 4 + 3 - k;
        endcase
    endfunction

    function automatic logic [63:0] model_move(input logic [63:0] g, input int d);
        logic [63:0] o;
        logic [3:0] a[4];
        logic [3:0] res[4];
        logic [3:0] v;
        int n, m, i;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            n = 0; m = 0; i = 0;
            for (int k = 0; k < 4; k++) begin
                a[k] = 4'd0; res[k] = 4'd0;
            end
            for (int k = 0; k < 4; k++) begin
                v = g[line_pos(d, r, k) * 4 +: 4];
                if (v != 4'd0) begin a[n] = v; n++; end
            end
            while (i < n) begin
                if (i + 1 < n && a[i] == a[i+1]) begin
                    res[m] = a[i] == 4'd15 ? 4'd15 : a[i] + 4'd1;
                    i += 2;
                end else begin
                    res[m] = a[i];
                    i += 1;
                end
                m++;
            end
            for (int k = 0; k < 4; k++) o[line_pos(d, r, k) * 4 +: 4] = res[k];
        end
        return o;
    endfunction

    function automatic int count_nz(input logic [63:0] g);
        int c = 0;
        for (int i = 0; i < 16; i++) if (g[i*4 +: 4] != 4'd0) c++;
        return c;
    endfunction

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget && !move_ready; i++) step();
        check("ready_wait", move_ready, 1);
    endtask

    task automatic do_load(input logic [63:0] g);
        wait_ready(60);
        load_en = 1'b1;
        load_grid = g;
        sb_push("load", g);
        step();
        load_en = 1'b0;
        sb_pop(grid);
    endtask

    task automatic check_spawn(input logic [63:0] base);
        int c = 0;
        logic [3:0] v;
        for (int i = 0; i < 16; i++) if (new_tiles[i]) c = i;
        v = grid[c*4 +: 4];
        check("spawn_onehot", $onehot(new_tiles), 1);
        check("spawn_cell_free", base[c*4 +: 4], 0);
        check("spawn_val", v == 4'd1 || v == 4'd2, 1);
        check("spawn_rest", grid & ~(64'hF << (c * 4)), base);
        check("fade_load", new_tiles_counter, 7);
    endtask

    task automatic do_move(input logic [63:0] g0, input int d);
        logic [63:0] e;
        e = model_move(g0, d);
        sb_push("commit", e);
        wait_ready(60);
        move_valid = 1'b1;
        move_dir = 2'(d);
        step();
        move_valid = 1'b0;
        check("accept_drop", move_ready, 0);
        repeat (4) step();
        check("ready_slide", move_ready, 0);
        step();
        sb_pop(grid);
        check("ready_commit", move_ready, e == g0);
        if (e != g0) begin
            wait_ready(20);
            check_spawn(e);
        end
    endtask

    initial begin
        logic [63:0] g;
        int d;
        step();
        check("rst_grid", grid, 0);
        check("rst_new_tiles", new_tiles, 0);
        check("rst_counter", new_tiles_counter, 0);
        check("rst_game_over", game_over, 0);
        check("rst_ready", move_ready, 0);
        rst_n = 1'b1;
        wait_ready(60);
        check("init_tiles", count_nz(grid), 2);
        check("init_fade", new_tiles_counter, 7);

        do_load(64'h0222);
        step();
        check("not_over", game_over, 0);
        do_move(64'h0222, 2);
        do_load(64'h1111);
        do_move(64'h1111, 2);
        do_load(64'h00FF);
        do_move(64'h00FF, 2);

        do_load(64'h0001);
        do_move(64'h0001, 2);
        check("nochg_new_tiles", new_tiles, 0);

        do_load(64'h1212_2121_1212_2121);
        step();
        check("game_over", game_over, 1);
        for (int i = 0; i < 4; i++) do_move(64'h1212_2121_1212_2121, i);
        check("over_held", game_over, 1);

        for (int n = 0; n < 8; n++) begin
            g = '0;
            for (int i = 0; i < 16; i++) g[i*4 +: 4] = 4'($urandom_range(0, 3));
            d = int'($urandom_range(0, 3));
            do_load(g);
            do_move(g, d);
        end

        do_load(64'h0222);
        do_move(64'h0222, 2);
        for (int i = 1; i <= 16; i++) begin
            frame_tick = 1'b1;
            sb_push("fade_step", i >= 14 ? 64'd0 : 64'(7 - i / 2));
            step();
            frame_tick = 1'b0;
            sb_pop(new_tiles_counter);
            step();
        end

        wait_ready(60);
        load_en = 1'b1;
        move_valid = 1'b1;
        load_grid = 64'h0000_0000_0000_0330;
        step();
        load_en = 1'b0;
        move_valid = 1'b0;
        check("load_over_move", grid, 64'h0330);
        check("load_stays_idle", move_ready, 1);

        new_game = 1'b1;
        load_en = 1'b1;
        move_valid = 1'b1;
        load_grid = '1;
        step();
        new_game = 1'b0;
        load_en = 1'b0;
        move_valid = 1'b0;
        check("new_game_clear", grid, 0);
        check("new_game_busy", move_ready, 0);
        wait_ready(60);
        check("new_game_tiles", count_nz(grid), 2);

        do_load(64'h0222);
        move_valid = 1'b1;
        move_dir = 2'd2;
        step();
        move_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_grid", grid, 0);
        check("midrst_ready", move_ready, 0);
        check("midrst_counter", new_tiles_counter, 0);
        step();
        rst_n = 1'b1;
        wait_ready(60);
        check("midrst_init_tiles", count_nz(grid), 2);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
